// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared 256-bit data-memory port (I-cache refill vs D-cache miss engine).
// Optional build macro DMEM_ARB_RR_EN: round-robin replaces fixed priority (requester 1 over 0).
module dmem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int ACK_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam bit              WD_EN   = (ACK_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t          state;
    state_t          state_nxt;
    state_t          pick;
    logic            in_grant;
    logic [TO_W-1:0] wd_cnt;
    logic            timeout;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // On a tie, favour whoever did not own the port last.
    always_comb begin
        pick = GRANT0;
        if (m0_enable_i && m1_enable_i) begin
            pick = last_grant ? GRANT0 : GRANT1;
        end else if (m1_enable_i) begin
            pick = GRANT1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && state_nxt == GRANT0) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && state_nxt == GRANT1) begin
            last_grant <= 1'b1;
        end
    end
`else
    always_comb begin
        pick = m1_enable_i ? GRANT1 : GRANT0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The grant is only released by a memory ack, never by the requester dropping enable.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_enable_i || m1_enable_i) begin
                    state_nxt = pick;
                end
            end
            GRANT0, GRANT1: begin
                if (mem_ack_i) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        grant_o      = 2'b00;
        case (state)
            GRANT0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = m0_write_i;
                mem_addr_o   = m0_addr_i;
                mem_data_o   = m0_data_i;
                m0_ack_o     = mem_ack_i;
                grant_o      = 2'b01;
            end
            GRANT1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = m1_write_i;
                mem_addr_o   = m1_addr_i;
                mem_data_o   = m1_data_i;
                m1_ack_o     = mem_ack_i;
                grant_o      = 2'b10;
            end
            default: ;
        endcase
    end

    assign in_grant = (state == GRANT0) || (state == GRANT1);

    // Watchdog: saturating count of grant cycles; the flag is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (in_grant) begin
            if (wd_cnt != TO_LAST) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (WD_EN && wd_cnt == TO_LAST) begin
                timeout <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_o = timeout;
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 10-cycle-ack memory model and ACK_TIMEOUT=16.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

`ifdef DMEM_ARB_RR_EN
    localparam logic [1:0] PAIR_FIRST = 2'b01;
`else
    localparam logic [1:0] PAIR_FIRST = 2'b10;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m0_enable = 1'b0, m0_write = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m0_rdata;
    logic              m0_ack;
    logic              m1_enable = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0, m1_rdata;
    logic              m1_ack;
    logic              mem_enable, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = {8{32'hDEAD_BEEF}};
    logic              mem_ack;
    logic [1:0]        grant;
    logic              timeout;

    logic ack_model = 1'b0;
    logic ack_force = 1'b0;
    logic model_en  = 1'b1;
    int   mcnt      = 0;

    int checks   = 0;
    int failures = 0;

    assign mem_ack = ack_model | ack_force;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(16), .TO_W(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(m0_enable), .m0_write_i(m0_write), .m0_addr_i(m0_addr),
        .m0_data_i(m0_wdata), .m0_data_o(m0_rdata), .m0_ack_o(m0_ack),
        .m1_enable_i(m1_enable), .m1_write_i(m1_write), .m1_addr_i(m1_addr),
        .m1_data_i(m1_wdata), .m1_data_o(m1_rdata), .m1_ack_o(m1_ack),
        .mem_enable_o(mem_enable), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .grant_o(grant), .timeout_o(timeout)
    );

    // Memory: one-cycle ack pulse 10 cycles after enable is seen.
    always @(posedge clk) begin
        if (!model_en || rst || !mem_enable) begin
            mcnt      <= 0;
            ack_model <= 1'b0;
        end else if (ack_model) begin
            mcnt      <= 0;
            ack_model <= 1'b0;
        end else if (mcnt == 9) begin
            ack_model <= 1'b1;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first grant cycle; returns in the RELEASE cycle (posedge+1).
    task automatic serve(input string tag, input logic [1:0] g, input logic [ADDR_W-1:0] addr,
                         input logic wr, input logic [DATA_W-1:0] wdata);
        int a0 = 0;
        int a1 = 0;
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk({tag, "_grant"}, grant, g);
                chk({tag, "_en"}, mem_enable, 1'b1);
                chk({tag, "_addr"}, mem_addr, addr);
                chk({tag, "_write"}, mem_write, wr);
                chk({tag, "_wdata"}, mem_wdata, wdata);
            end
            a0 += int'(m0_ack);
            a1 += int'(m1_ack);
            if (m0_ack || m1_ack) done = 1'b1;
            step();
        end
        chk({tag, "_acked"}, done, 1'b1);
        chk({tag, "_ack0"}, a0, g[0]);
        chk({tag, "_ack1"}, a1, g[1]);
        @(negedge clk);
        chk({tag, "_rel_en"}, mem_enable, 1'b0);
        chk({tag, "_rel_grant"}, grant, 2'b00);
        chk({tag, "_rel_ack"}, {m1_ack, m0_ack}, 2'b00);
        chk({tag, "_no_to"}, timeout, 1'b0);
    endtask

    task automatic to_idle(input string tag);
        step();
        @(negedge clk);
        chk({tag, "_idle_grant"}, grant, 2'b00);
        chk({tag, "_idle_en"}, mem_enable, 1'b0);
    endtask

    task automatic pair(input string tag);
        m0_enable = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_3000;
        m1_enable = 1'b1; m1_write = 1'b0; m1_addr = 32'h0000_4000;
        step();
        if (PAIR_FIRST == 2'b10) begin
            serve({tag, "_a"}, 2'b10, 32'h0000_4000, 1'b0, m1_wdata);
            m1_enable = 1'b0;
            to_idle({tag, "_a"});
            step();
            serve({tag, "_b"}, 2'b01, 32'h0000_3000, 1'b0, m0_wdata);
            m0_enable = 1'b0;
        end else begin
            serve({tag, "_a"}, 2'b01, 32'h0000_3000, 1'b0, m0_wdata);
            m0_enable = 1'b0;
            to_idle({tag, "_a"});
            step();
            serve({tag, "_b"}, 2'b10, 32'h0000_4000, 1'b0, m1_wdata);
            m1_enable = 1'b0;
        end
        to_idle({tag, "_b"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0t expected=finish", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        m0_wdata = {8{32'h0123_4567}};
        m1_wdata = {8{32'h89AB_CDEF}};
        repeat (3) step();
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_en", mem_enable, 1'b0);
        chk("rst_ack", {m1_ack, m0_ack}, 2'b00);
        chk("rst_to", timeout, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("bcast0", m0_rdata, {8{32'hDEAD_BEEF}});
        chk("bcast1", m1_rdata, {8{32'hDEAD_BEEF}});
        step();
        rst = 1'b0;

        // Lone I-cache read
        m0_enable = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_0400;
        @(negedge clk);
        chk("t1_not_yet", grant, 2'b00);
        step();
        serve("t1", 2'b01, 32'h0000_0400, 1'b0, m0_wdata);
        m0_enable = 1'b0;
        to_idle("t1");

        // D-cache writeback then refill with enable held across
        m1_enable = 1'b1; m1_write = 1'b1; m1_addr = 32'h0000_1000; m1_wdata = {32{8'hA5}};
        step();
        serve("t3_wb", 2'b10, 32'h0000_1000, 1'b1, {32{8'hA5}});
        m1_write = 1'b0; m1_addr = 32'h0000_2000;
        to_idle("t3");
        step();
        serve("t3_rf", 2'b10, 32'h0000_2000, 1'b0, {32{8'hA5}});
        m1_enable = 1'b0;
        to_idle("t3_rf");

        // Simultaneous requests, twice
        pair("t2_p1");
        pair("t2_p2");

        // Reset in the middle of a grant
        m0_enable = 1'b1; m0_addr = 32'h0000_0800;
        step();
        repeat (4) step();
        rst = 1'b1; m0_enable = 1'b0;
        @(negedge clk);
        chk("t5_still_g0", grant, 2'b01);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_idle", grant, 2'b00);
        chk("t5_en", mem_enable, 1'b0);
        step();
        ack_force = 1'b1;
        @(negedge clk);
        chk("t5_late_ack", {m1_ack, m0_ack}, 2'b00);
        step();
        ack_force = 1'b0;
        @(negedge clk);
        chk("t5_stay_idle", grant, 2'b00);

        // Stray ack in idle
        step();
        ack_force = 1'b1;
        @(negedge clk);
        chk("t6_ack", {m1_ack, m0_ack}, 2'b00);
        chk("t6_grant", grant, 2'b00);
        step();
        ack_force = 1'b0;
        @(negedge clk);
        chk("t6_idle", grant, 2'b00);
        chk("t6_en", mem_enable, 1'b0);

        // Watchdog with a memory that never acks
        step();
        model_en = 1'b0;
        m1_enable = 1'b1; m1_write = 1'b0; m1_addr = 32'h0000_5000;
        step();
        repeat (15) step();
        @(negedge clk);
        chk("t4_c16_to", timeout, 1'b0);
        chk("t4_c16_grant", grant, 2'b10);
        step();
        @(negedge clk);
        chk("t4_c17_to", timeout, 1'b1);
        chk("t4_c17_grant", grant, 2'b10);
        repeat (5) step();
        @(negedge clk);
        chk("t4_sticky", timeout, 1'b1);
        chk("t4_held", grant, 2'b10);
        step();
        rst = 1'b1; m1_enable = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_to", timeout, 1'b0);
        chk("t4_rst_grant", grant, 2'b00);
        chk("t4_rst_en", mem_enable, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
